// File: rtl/id_operand_stage_pkg.sv
// Shared pipeline definitions for the operand-fetch stage.
//   PIPE_XLEN    : operand / bypass data width used by the shared structs
//   REG_X0       : hard-wired zero register index
//   bypass_src_t : one forwarding producer (valid, wr_en, rd, data)
//   ex_payload_t : instruction payload handed to the execute stage
//   src_match    : true when a producer supplies a given, actually-read source
package id_operand_stage_pkg;

  localparam int PIPE_XLEN = 64;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [4:0]           rd;
    logic [PIPE_XLEN-1:0] data;
  } bypass_src_t;

  typedef struct packed {
    logic [63:0]          pc;
    logic [PIPE_XLEN-1:0] rs1_val;
    logic [PIPE_XLEN-1:0] rs2_val;
    logic [4:0]           rd;
    logic                 wr_en;
    logic                 is_load;
  } ex_payload_t;

  // A producer only counts when it really writes a non-zero destination that
  // this instruction really reads.
  function automatic logic src_match(input bypass_src_t src,
                                     input logic [4:0]  index,
                                     input logic        use_src);
    return src.valid && src.wr_en && (src.rd == index) &&
           (src.rd != REG_X0) && use_src;
  endfunction

endpackage

// File: rtl/id_operand_stage_operand_bypass_mux.sv
// Combinational operand resolver for one source register.
// Ports:
//   index      : source register index
//   use_src    : instruction actually reads this source
//   ex_src     : EX-stage producer (data undefined when ex_is_load)
//   ex_is_load : EX producer is a load
//   mem_src    : MEM-stage producer (load data included)
//   wb_src     : WB-stage producer (same value the register file writes)
//   gpr_data   : register-file read data
//   operand    : resolved operand
//   ex_hit     : EX producer matches this source (used for load-use detection)
module operand_bypass_mux
  import id_operand_stage_pkg::*;
(
  input  logic [4:0]           index,
  input  logic                 use_src,
  input  bypass_src_t          ex_src,
  input  logic                 ex_is_load,
  input  bypass_src_t          mem_src,
  input  bypass_src_t          wb_src,
  input  logic [PIPE_XLEN-1:0] gpr_data,
  output logic [PIPE_XLEN-1:0] operand,
  output logic                 ex_hit
);

  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = src_match(ex_src,  index, use_src);
  assign mem_hit = src_match(mem_src, index, use_src);
  assign wb_hit  = src_match(wb_src,  index, use_src);

  // Youngest producer wins. A load in EX has no data yet; the stage stalls on
  // it, so it is skipped here rather than forwarding garbage.
  always_comb begin
    operand = gpr_data;
    if (index == REG_X0) begin
      operand = '0;
    end else if (ex_hit && !ex_is_load) begin
      operand = ex_src.data;
    end else if (mem_hit) begin
      operand = mem_src.data;
    end else if (wb_hit) begin
      // The register file only updates at the edge, so same-cycle WB data
      // must come from the bypass.
      operand = wb_src.data;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Operand-fetch stage between decode and execute.
// Reads the register file, forwards from EX/MEM/WB, stalls one cycle on a
// load-use hazard and holds the resolved instruction in a pipeline register.
// Ports:
//   clk, rstn                 : clock, synchronous active-low reset
//   flush                     : drop held entry and incoming instruction
//   in_valid/in_ready         : decode handshake
//   in_pc, in_rs1/2, in_rd    : incoming instruction fields
//   in_use_rs1/2              : sources actually read
//   in_wr_en, in_is_load      : incoming instruction flags
//   index_rs1/2, gpr_data_*   : register-file read port
//   ex_*, mem_*, wb_*         : bypass producers
//   out_valid/out_ready       : execute handshake
//   out_pc..out_is_load       : registered payload for execute
//   stall_cnt                 : saturating count of load-use stall cycles
//
// Handshake: a transfer happens on a posedge where valid && ready. A valid
// side holds its payload stable until the transfer; ready may depend on
// valid combinationally but valid never depends on ready.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int XLEN  = 64,  // must equal PIPE_XLEN
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic             in_wr_en,
  input  logic             in_is_load,
  output logic [4:0]       index_rs1,
  output logic [4:0]       index_rs2,
  input  logic [XLEN-1:0]  gpr_data_rs1,
  input  logic [XLEN-1:0]  gpr_data_rs2,
  input  logic             ex_valid,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_valid,
  input  logic             mem_wr_en,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_valid,
  input  logic             wb_wr_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pc,
  output logic [XLEN-1:0]  out_rs1_val,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic [4:0]       out_rd,
  output logic             out_wr_en,
  output logic             out_is_load,
  output logic [CNT_W-1:0] stall_cnt
);

  bypass_src_t ex_src;
  bypass_src_t mem_src;
  bypass_src_t wb_src;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            ex_hit_rs1;
  logic            ex_hit_rs2;
  logic            hazard;

  ex_payload_t      out_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_q;

  assign index_rs1 = in_rs1;
  assign index_rs2 = in_rs2;

  assign ex_src  = '{valid: ex_valid,  wr_en: ex_wr_en,  rd: ex_rd,  data: ex_result};
  assign mem_src = '{valid: mem_valid, wr_en: mem_wr_en, rd: mem_rd, data: mem_result};
  assign wb_src  = '{valid: wb_valid,  wr_en: wb_wr_en,  rd: wb_rd,  data: wb_data};

  operand_bypass_mux u_mux_rs1 (
    .index      (in_rs1),
    .use_src    (in_use_rs1),
    .ex_src     (ex_src),
    .ex_is_load (ex_is_load),
    .mem_src    (mem_src),
    .wb_src     (wb_src),
    .gpr_data   (gpr_data_rs1),
    .operand    (rs1_val),
    .ex_hit     (ex_hit_rs1)
  );

  operand_bypass_mux u_mux_rs2 (
    .index      (in_rs2),
    .use_src    (in_use_rs2),
    .ex_src     (ex_src),
    .ex_is_load (ex_is_load),
    .mem_src    (mem_src),
    .wb_src     (wb_src),
    .gpr_data   (gpr_data_rs2),
    .operand    (rs2_val),
    .ex_hit     (ex_hit_rs2)
  );

  // A load in EX cannot forward yet; one bubble lets it reach MEM.
  assign hazard   = in_valid && (ex_hit_rs1 || ex_hit_rs2) && ex_is_load;
  assign in_ready = !hazard && !flush && (!valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_q.pc      <= in_pc;
      out_q.rs1_val <= rs1_val;
      out_q.rs2_val <= rs2_val;
      out_q.rd      <= in_rd;
      out_q.wr_en   <= in_wr_en;
      out_q.is_load <= in_is_load;
      valid_q       <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating: once all-ones the counter stays put.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = out_q.pc;
  assign out_rs1_val = out_q.rs1_val;
  assign out_rs2_val = out_q.rs2_val;
  assign out_rd      = out_q.rd;
  assign out_wr_en   = out_q.wr_en;
  assign out_is_load = out_q.is_load;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 3;  // small so saturation is reachable quickly

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_pc;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [4:0]       in_rd;
  logic             in_use_rs1;
  logic             in_use_rs2;
  logic             in_wr_en;
  logic             in_is_load;
  logic [4:0]       index_rs1;
  logic [4:0]       index_rs2;
  logic [XLEN-1:0]  gpr_data_rs1;
  logic [XLEN-1:0]  gpr_data_rs2;
  logic             ex_valid;
  logic             ex_wr_en;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic [XLEN-1:0]  ex_result;
  logic             mem_valid;
  logic             mem_wr_en;
  logic [4:0]       mem_rd;
  logic [XLEN-1:0]  mem_result;
  logic             wb_valid;
  logic             wb_wr_en;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_pc;
  logic [XLEN-1:0]  out_rs1_val;
  logic [XLEN-1:0]  out_rs2_val;
  logic [4:0]       out_rd;
  logic             out_wr_en;
  logic             out_is_load;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  id_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_wr_en(in_wr_en), .in_is_load(in_is_load),
    .index_rs1(index_rs1), .index_rs2(index_rs2),
    .gpr_data_rs1(gpr_data_rs1), .gpr_data_rs2(gpr_data_rs2),
    .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
    .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [63:0] gpr1;
    logic [63:0] gpr2;
    logic        ex_v;
    logic        ex_w;
    logic        ex_ld;
    logic [4:0]  ex_rd;
    logic [63:0] ex_res;
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [63:0] mem_res;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [63:0] wb_dat;
    logic [63:0] exp1;
    logic [63:0] exp2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic use1, input logic use2,
    input logic [63:0] gpr1, input logic [63:0] gpr2,
    input logic ex_v, input logic ex_w, input logic ex_ld,
    input logic [4:0] ex_rd, input logic [63:0] ex_res,
    input logic mem_v, input logic [4:0] mem_rd, input logic [63:0] mem_res,
    input logic wb_v, input logic [4:0] wb_rd, input logic [63:0] wb_dat,
    input logic [63:0] exp1, input logic [63:0] exp2);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
    v.gpr1 = gpr1; v.gpr2 = gpr2;
    v.ex_v = ex_v; v.ex_w = ex_w; v.ex_ld = ex_ld; v.ex_rd = ex_rd; v.ex_res = ex_res;
    v.mem_v = mem_v; v.mem_rd = mem_rd; v.mem_res = mem_res;
    v.wb_v = wb_v; v.wb_rd = wb_rd; v.wb_dat = wb_dat;
    v.exp1 = exp1; v.exp2 = exp2;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wr_en = 1'b0; in_is_load = 1'b0;
    gpr_data_rs1 = '0; gpr_data_rs2 = '0;
    ex_valid = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_result = '0;
    mem_valid = 1'b0; mem_wr_en = 1'b0; mem_rd = '0; mem_result = '0;
    wb_valid = 1'b0; wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_use_rs1 = v.use1; in_use_rs2 = v.use2;
    gpr_data_rs1 = v.gpr1; gpr_data_rs2 = v.gpr2;
    ex_valid = v.ex_v; ex_wr_en = v.ex_w; ex_is_load = v.ex_ld;
    ex_rd = v.ex_rd; ex_result = v.ex_res;
    mem_valid = v.mem_v; mem_wr_en = 1'b1; mem_rd = v.mem_rd; mem_result = v.mem_res;
    wb_valid = v.wb_v; wb_wr_en = 1'b1; wb_rd = v.wb_rd; wb_data = v.wb_dat;
  endtask

  // one clock step: edge, then sample at the following negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // hazard on rs1 = x1 from a load in EX
  task automatic drive_hazard();
    clear_inputs();
    in_valid = 1'b1; in_rs1 = 5'd1; in_use_rs1 = 1'b1;
    ex_valid = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
  endtask

  initial begin
    // stimulus table
    //          rs1 rs2 u1 u2 gpr1      gpr2     exv exw exld exrd exres   memv memrd memres  wbv wbrd wbdat   exp1      exp2
    vecs.push_back(mk(5, 6, 1, 1, 64'h11,   64'h22,  0, 0, 0, 0, 64'h0,  0, 0, 64'h0,  0, 0, 64'h0,  64'h11,   64'h22));
    vecs.push_back(mk(7, 8, 1, 1, 64'h70,   64'h80,  1, 1, 0, 7, 64'hA,  1, 7, 64'hB,  1, 7, 64'hC,  64'hA,    64'h80));
    vecs.push_back(mk(7, 8, 1, 1, 64'h70,   64'h80,  0, 0, 0, 0, 64'hA,  1, 7, 64'hB,  1, 7, 64'hC,  64'hB,    64'h80));
    vecs.push_back(mk(7, 8, 1, 1, 64'h70,   64'h80,  0, 0, 0, 0, 64'hA,  0, 0, 64'hB,  1, 7, 64'hC,  64'hC,    64'h80));
    vecs.push_back(mk(0, 0, 1, 1, 64'hFFFF, 64'hFFFF,1, 1, 0, 0, 64'hA,  1, 0, 64'hB,  1, 0, 64'hC,  64'h0,    64'h0));
    vecs.push_back(mk(7, 9, 0, 1, 64'h77,   64'h99,  1, 1, 0, 7, 64'hA,  1, 9, 64'h9B, 0, 0, 64'h0,  64'h77,   64'h9B));
    vecs.push_back(mk(7, 9, 1, 1, 64'h77,   64'h99,  1, 0, 0, 7, 64'hA,  0, 0, 64'h0,  1, 9, 64'h9C, 64'h77,   64'h9C));
    vecs.push_back(mk(5, 9, 1, 1, 64'h55,   64'h99,  1, 1, 1, 12,64'hA,  0, 0, 64'h0,  0, 0, 64'h0,  64'h55,   64'h99));
    vecs.push_back(mk(3, 3, 1, 1, 64'h33,   64'h33,  1, 1, 0, 3, 64'hE3, 1, 3, 64'hB3, 0, 0, 64'h0,  64'hE3,   64'hE3));
    vecs.push_back(mk(31,30,1, 1, 64'h1F,   64'h1E,  1, 1, 0, 30,64'hDEAD_BEEF_0000_0001, 1, 31, 64'hFEED_0000_0000_1234, 0, 0, 64'h0, 64'hFEED_0000_0000_1234, 64'hDEAD_BEEF_0000_0001));

    // reset
    clear_inputs();
    out_ready = 1'b1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset stall_cnt", 64'(stall_cnt), 64'h0);
    check("reset out_pc", out_pc, 64'h0);
    check("reset out_rs1_val", out_rs1_val, 64'h0);
    check("reset out_rd", 64'(out_rd), 64'h0);
    rstn = 1'b1;
    step();

    // table-driven bypass vectors, one instruction per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      clear_inputs();
      apply_vec(vecs[i]);
      in_valid = 1'b1;
      in_pc = 64'h1000 + 64'(i * 4);
      in_rd = 5'(i + 1);
      in_wr_en = 1'b1;
      in_is_load = i[0];
      out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'h1);
      check($sformatf("vec%0d index_rs1", i), 64'(index_rs1), 64'(vecs[i].rs1));
      check($sformatf("vec%0d index_rs2", i), 64'(index_rs2), 64'(vecs[i].rs2));
      step();
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'h1);
      check($sformatf("vec%0d rs1_val", i), out_rs1_val, vecs[i].exp1);
      check($sformatf("vec%0d rs2_val", i), out_rs2_val, vecs[i].exp2);
      check($sformatf("vec%0d out_pc", i), out_pc, 64'h1000 + 64'(i * 4));
      check($sformatf("vec%0d out_rd", i), 64'(out_rd), 64'(i + 1));
      check($sformatf("vec%0d out_is_load", i), 64'(out_is_load), 64'(i[0]));
    end

    // load-use: load to x3 in EX, consumer reads x3 on rs2
    clear_inputs();
    in_valid = 1'b1; in_pc = 64'h1800; in_rd = 5'd10; in_wr_en = 1'b1;
    in_rs1 = 5'd4; in_use_rs1 = 1'b1; gpr_data_rs1 = 64'h44;
    in_rs2 = 5'd3; in_use_rs2 = 1'b1; gpr_data_rs2 = 64'h33;
    ex_valid = 1'b1; ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3; ex_result = 64'hBAD;
    #1;
    check("loaduse in_ready", 64'(in_ready), 64'h0);
    step();
    exp_cnt = 1;
    check("loaduse bubble", 64'(out_valid), 64'h0);
    check("loaduse stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    ex_valid = 1'b0; ex_is_load = 1'b0;
    mem_valid = 1'b1; mem_wr_en = 1'b1; mem_rd = 5'd3; mem_result = 64'h55;
    #1;
    check("loaduse in_ready after", 64'(in_ready), 64'h1);
    step();
    check("loaduse out_valid", 64'(out_valid), 64'h1);
    check("loaduse rs2 from mem", out_rs2_val, 64'h55);
    check("loaduse rs1", out_rs1_val, 64'h44);
    check("loaduse stall_cnt hold", 64'(stall_cnt), 64'(exp_cnt));

    // backpressure: capture one entry, then hold it for 3 cycles
    clear_inputs();
    in_valid = 1'b1; in_pc = 64'h2000; in_rs1 = 5'd1; in_use_rs1 = 1'b1;
    gpr_data_rs1 = 64'h1234; in_rd = 5'd2;
    step();
    check("bp captured", out_rs1_val, 64'h1234);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_pc = 64'h3000 + 64'(k); gpr_data_rs1 = 64'hDEAD + 64'(k);
      #1;
      check($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'h0);
      step();
      check($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'h1);
      check($sformatf("bp%0d rs1 stable", k), out_rs1_val, 64'h1234);
      check($sformatf("bp%0d pc stable", k), out_pc, 64'h2000);
    end
    // flush with a new instruction and a live hazard: nothing captured, no count
    drive_hazard();
    in_pc = 64'h4000; flush = 1'b1;
    #1;
    check("flush in_ready", 64'(in_ready), 64'h0);
    step();
    check("flush out_valid", 64'(out_valid), 64'h0);
    check("flush no stall count", 64'(stall_cnt), 64'(exp_cnt));
    clear_inputs();
    out_ready = 1'b1;
    step();
    check("flush not captured", 64'(out_valid), 64'h0);
    check("flush pc kept", out_pc, 64'h2000);

    // build stall_cnt to 4, then reset mid-stall
    drive_hazard();
    for (int k = 0; k < 3; k++) begin
      step();
      exp_cnt++;
      check($sformatf("stall%0d cnt", k), 64'(stall_cnt), 64'(exp_cnt));
      check($sformatf("stall%0d bubble", k), 64'(out_valid), 64'h0);
    end
    rstn = 1'b0;
    step();
    exp_cnt = 0;
    check("rst mid-stall out_valid", 64'(out_valid), 64'h0);
    check("rst mid-stall stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    rstn = 1'b1;

    // saturation at all-ones
    for (int k = 0; k < 9; k++) begin
      step();
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      check($sformatf("sat%0d cnt", k), 64'(stall_cnt), 64'(exp_cnt));
    end

    // load in EX matching an unused source is not a hazard
    in_use_rs1 = 1'b0;
    #1;
    check("unused src no hazard", 64'(in_ready), 64'h1);
    step();
    check("unused src captured", 64'(out_valid), 64'h1);
    check("unused src cnt hold", 64'(stall_cnt), 64'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Operand-fetch stage between decode and execute in the 64-bit in-order pipeline.
- Drives register-file read indices and combines the register-file read data with bypass values from EX, MEM and WB.
- Detects load-use hazards and stalls on them.
- Holds the resolved operands in a valid/ready pipeline register that feeds the execute stage.
- Keeps a performance counter of hazard-stall cycles.

Parameters:
- XLEN, 64, data width of operands and bypass buses
- CNT_W, 32, width of the stall counter (saturating)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- flush  in  1  kill the held entry and any incoming instruction (branch redirect)
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  64  instruction PC
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_use_rs1, in_use_rs2  in  1 each  source actually read
- in_wr_en, in_is_load  in  1 each  writes rd / is a load
- index_rs1, index_rs2  out  5 each  to register file, equal to in_rs1/in_rs2 (combinational)
- gpr_data_rs1, gpr_data_rs2  in  XLEN each  register-file read data (combinational)
- ex_valid, ex_wr_en, ex_is_load  in  1 each  EX-stage producer info
- ex_rd  in  5  EX destination
- ex_result  in  XLEN  EX result (undefined when ex_is_load)
- mem_valid, mem_wr_en  in  1 each  MEM-stage producer info
- mem_rd  in  5  MEM destination
- mem_result  in  XLEN  MEM result, including load data
- wb_valid, wb_wr_en  in  1 each  WB-stage producer info
- wb_rd  in  5  WB destination
- wb_data  in  XLEN  same value the register file writes this edge
- out_valid  out  1  entry valid for execute
- out_ready  in  1  execute accepts
- out_pc  out  64  registered copy of in_pc
- out_rs1_val, out_rs2_val  out  XLEN each  resolved operands
- out_rd  out  5  registered destination
- out_wr_en, out_is_load  out  1 each  registered flags
- stall_cnt  out  CNT_W  load-use stall cycles

Behaviour:
- Reset (rstn=0 at posedge): all registered outputs go to 0, including out_valid and stall_cnt.
- Source match for a producer P on source s: P_valid && P_wr_en && P_rd==in_rs && P_rd!=0 && in_use_s.
- Operand select per source, in priority order:
  1. Index 0 gives 0.
  2. EX match, not a load, gives ex_result.
  3. MEM match gives mem_result.
  4. WB match gives wb_data.
  5. Otherwise gpr_data. The register file writes on the clock edge, so same-cycle WB data must be bypassed.
- hazard = in_valid && (EX match on rs1 or rs2) && ex_is_load.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Capture: on posedge, if in_valid && in_ready, load out_* with the resolved operands and in_* fields, and set out_valid=1.
- Drain: else if out_valid && out_ready, set out_valid=0. The stage inserts a bubble during a hazard.
- Hold: else keep all out_* stable. Operands must not change while out_valid && !out_ready.
- flush has priority over capture: out_valid goes to 0 next cycle and the incoming instruction is dropped.
- Reset has priority over flush.
- stall_cnt increments once per cycle in which hazard=1 and flush=0. It saturates at all-ones and never wraps.
- Latency: one cycle from acceptance to out_valid. Throughput is one instruction per cycle when unstalled.
- A hazard lasts exactly one cycle when the pipeline advances, because the load moves to MEM and then forwards from there.

Decomposition:
- Shared pipeline package holds:
  - constant REG_X0 = 5'd0
  - struct type for the bypass source (valid, wr_en, rd, data)
  - typedef for the EX-stage payload (pc, rs1_val, rs2_val, rd, wr_en, is_load)
- One natural sub-module, operand_bypass_mux:
  - purely combinational
  - inputs: one index, its use flag, the three bypass sources and the gpr data
  - output: the resolved operand
  - instantiated twice, once for rs1 and once for rs2

Test Plan:
- No hazard: rs1=5 with gpr=0x11, rs2=6 with gpr=0x22, no producers -> one cycle later out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22.
- Priority: rs1=7; ex_result=0xA, mem_result=0xB, wb_data=0xC all target x7, EX not a load -> out_rs1_val=0xA. Drop the EX match -> 0xB. Drop the MEM match as well -> 0xC.
- x0: rs1=0 with all producers writing x0 and gpr=0xFFFF -> out_rs1_val=0.
- Load-use: EX load to x3, in rs2=3, in_use_rs2=1 -> in_ready=0 for 1 cycle, out_valid=0 bubble, stall_cnt increments by 1. Next cycle MEM forwards mem_result=0x55 -> out_rs2_val=0x55.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Then flush=1 with in_valid=1 -> out_valid=0 next cycle, and the instruction is not captured.
- Reset mid-stall: rstn=0 during a hazard with stall_cnt=4 -> out_valid=0 and stall_cnt=0 after the edge.
